// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: encryptor state encoding and the printable-character rule
// used by both the encrypt and decrypt memory blocks.
package rc4_pkg;

    localparam logic [7:0] CHAR_LO    = 8'd97;
    localparam logic [7:0] CHAR_HI    = 8'd122;
    localparam logic [7:0] CHAR_SPACE = 8'd32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SI,
        ST_RD_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_CHECK,
        ST_WR_C,
        ST_NEXT,
        ST_DONE
    } enc_state_e;

    function automatic logic byte_valid(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/mem_rd_timer.sv
// Wait counter for registered-address/registered-output RAMs: strobes last_o on the
// final cycle of a READ_LAT+1 cycle read window.
module mem_rd_timer #(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic last_o
);

    localparam int CW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

    logic [CW-1:0] cnt_q;

    assign last_o = enable_i && (cnt_q == CW'(READ_LAT));

    // Wraps to zero on the strobe so back-to-back read states each get a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= last_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/encrypt_memory.sv
// RC4 PRGA encryptor: walks the scheduled S memory to produce keystream bytes and
// writes ciphertext = keystream ^ plaintext, aborting on a non-printable plaintext byte.
module encrypt_memory
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter int READ_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_rdata,
    output logic [7:0] p_addr,
    input  logic [7:0] p_rdata,
    output logic [7:0] c_addr,
    output logic [7:0] c_wdata,
    output logic       c_wren
);

    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    enc_state_e state_q;
    logic [7:0] i_q, j_q, k_q, si_q, sj_q, f_q, p_q;
    logic       busy_q, done_q, err_q, s_wren_q, c_wren_q;
    logic [7:0] s_addr_q, s_wdata_q, p_addr_q, c_addr_q, c_wdata_q;
    logic [7:0] i_d, j_d, f_addr_d, c_wdata_d;
    logic       rd_state, rd_last;

    assign rd_state  = (state_q == ST_RD_SI) || (state_q == ST_RD_SJ) || (state_q == ST_RD_F);
    assign i_d       = i_q + 8'd1;
    assign j_d       = j_q + s_rdata;
    assign f_addr_d  = si_q + sj_q;
    assign c_wdata_d = f_q ^ p_q;

    mem_rd_timer #(.READ_LAT(READ_LAT)) u_rd_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!rd_state),
        .enable_i (rd_state),
        .last_o   (rd_last)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wren  = s_wren_q;
    assign p_addr  = p_addr_q;
    assign c_addr  = c_addr_q;
    assign c_wdata = c_wdata_q;
    assign c_wren  = c_wren_q;

    // Outputs are registered on the edge entering each state, so every address is
    // stable for the whole read window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            f_q       <= '0;
            p_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_wren_q  <= 1'b0;
            c_wren_q  <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            p_addr_q  <= '0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // i is cleared and pre-incremented in one step: first index is 1.
                        i_q      <= 8'd1;
                        j_q      <= '0;
                        k_q      <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        s_addr_q <= 8'd1;
                        state_q  <= ST_RD_SI;
                    end
                end
                ST_RD_SI: begin
                    if (rd_last) begin
                        si_q     <= s_rdata;
                        j_q      <= j_d;
                        s_addr_q <= j_d;
                        state_q  <= ST_RD_SJ;
                    end
                end
                ST_RD_SJ: begin
                    if (rd_last) begin
                        sj_q      <= s_rdata;
                        s_addr_q  <= i_q;
                        s_wdata_q <= s_rdata;
                        s_wren_q  <= 1'b1;
                        state_q   <= ST_WR_SI;
                    end
                end
                ST_WR_SI: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= si_q;
                    state_q   <= ST_WR_SJ;
                end
                ST_WR_SJ: begin
                    s_wren_q <= 1'b0;
                    s_addr_q <= f_addr_d;
                    p_addr_q <= k_q;
                    state_q  <= ST_RD_F;
                end
                ST_RD_F: begin
                    if (rd_last) begin
                        f_q     <= s_rdata;
                        p_q     <= p_rdata;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (byte_valid(p_q)) begin
                        c_addr_q  <= k_q;
                        c_wdata_q <= c_wdata_d;
                        c_wren_q  <= 1'b1;
                        state_q   <= ST_WR_C;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_WR_C: begin
                    c_wren_q <= 1'b0;
                    state_q  <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (k_q == K_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        k_q      <= k_q + 8'd1;
                        i_q      <= i_d;
                        s_addr_q <= i_d;
                        state_q  <= ST_RD_SI;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_memory.sv
// Bench for encrypt_memory: RAM models with two-cycle read latency, a ciphertext
// scoreboard fed by an RC4 reference, and directed runs for abort, reset and restart cases.
module tb_encrypt_memory;

    localparam int MSG_LEN  = 32;
    localparam int READ_LAT = 2;
    localparam int BUDGET   = 20000;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done, err, s_wren, c_wren;
    logic [7:0] s_addr, s_wdata, s_rdata, p_addr, p_rdata, c_addr, c_wdata;

    always #5 clk = ~clk;

    encrypt_memory #(.MSG_LEN(MSG_LEN), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .p_addr(p_addr), .p_rdata(p_rdata),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_wren(c_wren)
    );

    // Memories: registered address then registered output (q valid 2 cycles after address).
    logic [7:0] s_mem [256];
    logic [7:0] p_mem [256];
    logic [7:0] c_mem [256];
    bit         c_written [256];
    logic [7:0] s_img [256];
    logic [7:0] p_img [256];
    logic       ld = 1'b0;
    logic [7:0] s_ar, s_q, p_ar, p_q;

    assign s_rdata = s_q;
    assign p_rdata = p_q;

    always @(posedge clk) begin
        s_ar <= s_addr;
        s_q  <= s_mem[s_ar];
        p_ar <= p_addr;
        p_q  <= p_mem[p_ar];
        if (ld) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]     <= s_img[a];
                p_mem[a]     <= p_img[a];
                c_written[a] <= 1'b0;
            end
        end else begin
            if (s_wren) s_mem[s_addr] <= s_wdata;
            if (c_wren) begin
                c_mem[c_addr]     <= c_wdata;
                c_written[c_addr] <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t expq[$];

    int n_checks = 0;
    int n_fails  = 0;
    int s_wr_cnt = 0;
    int c_wr_cnt = 0;
    int done_cnt = 0;

    // Monitor: every ciphertext write is popped against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (s_wren) s_wr_cnt++;
            if (done) done_cnt++;
            if (c_wren) begin
                c_wr_cnt++;
                n_checks++;
                if (expq.size() == 0) begin
                    n_fails++;
                    $display("FAIL c_write_unexpected: got addr %0d data %02h, required no write", c_addr, c_wdata);
                end else begin
                    e = expq.pop_front();
                    if (c_addr !== e.a || c_wdata !== e.d) begin
                        n_fails++;
                        $display("FAIL c_write: got addr %0d data %02h, required addr %0d data %02h",
                                 c_addr, c_wdata, e.a, e.d);
                    end
                end
                n_checks++;
                if (s_wren !== 1'b0) begin
                    n_fails++;
                    $display("FAIL wren_overlap: got s_wren %0b with c_wren, required 0", s_wren);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic bit ref_valid(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
    endfunction

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    endtask

    task automatic set_ksa(input logic [23:0] key);
        logic [7:0] j, t, kb;
        set_identity();
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            case (a % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + s_img[a] + kb;
            t = s_img[a]; s_img[a] = s_img[j]; s_img[j] = t;
        end
    endtask

    task automatic set_pt(input string s);
        for (int a = 0; a < 256; a++) p_img[a] = (a < s.len()) ? s[a] : 8'h20;
    endtask

    task automatic load_mems();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    // Reference RC4 PRGA over a private copy of the S image.
    task automatic gen_expected(input int len);
        logic [7:0] ms [256];
        logic [7:0] i, j, t, fa;
        exp_t e;
        for (int a = 0; a < 256; a++) ms[a] = s_img[a];
        i = 8'd0; j = 8'd0;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            j = j + ms[i];
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            fa = ms[i] + ms[j];
            if (!ref_valid(p_img[k])) break;
            e.a = 8'(k);
            e.d = ms[fa] ^ p_img[k];
            expq.push_back(e);
        end
    endtask

    // Cycle 1 is the cycle in which start is high and accepted.
    task automatic run(input int pulse_at, output int dcyc);
        int n;
        @(negedge clk); start = 1'b1; n = 1;
        do begin
            @(negedge clk); n++;
            start = (n == pulse_at);
        end while (!done && n < BUDGET);
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        dcyc = n;
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_drop", busy, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, done, err, s_wren, c_wren}, 5'd0);
        chk({tag, "_s"}, {s_addr, s_wdata}, 16'd0);
        chk({tag, "_pc"}, {p_addr, c_addr, c_wdata}, 24'd0);
    endtask

    int dcyc, sw0, cw0, dn0, w, n, nwr;
    logic [7:0] di, dj, dt, dfa;
    logic [7:0] dm [256];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;

        // "ab" then 'A': c[0]=61^02=63, c[1]=62^05=67; byte 2 swaps s[3]/s[5] then aborts at cycle 42.
        set_identity();
        set_pt("abA");
        load_mems();
        expq.push_back('{a: 8'd0, d: 8'h63});
        expq.push_back('{a: 8'd1, d: 8'h67});
        sw0 = s_wr_cnt; cw0 = c_wr_cnt; dn0 = done_cnt;
        run(0, dcyc);
        chk("abort_done_cycle", dcyc, 42);
        chk("abort_err", err, 1'b1);
        chk("abort_c2_unwritten", c_written[2], 1'b0);
        chk("abort_c_writes", c_wr_cnt - cw0, 2);
        chk("abort_s_writes", s_wr_cnt - sw0, 6);
        chk("abort_done_pulses", done_cnt - dn0, 1);
        chk("abort_s2", s_mem[2], 8'd3);
        chk("abort_s3", s_mem[3], 8'd5);
        chk("abort_s5", s_mem[5], 8'd2);
        chk("abort_queue_empty", expq.size(), 0);

        // 32 spaces, identity S, stray start pulse mid-run.
        set_identity();
        set_pt("");
        load_mems();
        gen_expected(MSG_LEN);
        sw0 = s_wr_cnt; cw0 = c_wr_cnt; dn0 = done_cnt;
        run(100, dcyc);
        chk("full_done_cycle", dcyc, MSG_LEN * 14 + 2);
        chk("full_err", err, 1'b0);
        chk("full_c_writes", c_wr_cnt - cw0, 32);
        chk("full_s_writes", s_wr_cnt - sw0, 64);
        chk("full_done_pulses", done_cnt - dn0, 1);
        chk("full_queue_empty", expq.size(), 0);

        // Asynchronous reset during WR_SJ of byte 5 (12th S write), then a clean restart.
        set_identity();
        set_pt("hello world from the fpga board");
        load_mems();
        gen_expected(MSG_LEN);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0; n = 0;
        while (n < BUDGET) begin
            if (s_wren) w++;
            if (w == 12) break;
            @(negedge clk); n++;
        end
        chk("wr_sj5_reached", w, 12);
        #2 reset = 1'b1;
        #1 chk_outputs_zero("async_reset");
        expq.delete();
        @(negedge clk); reset = 1'b0;
        load_mems();
        gen_expected(MSG_LEN);
        run(0, dcyc);
        chk("restart_done_cycle", dcyc, MSG_LEN * 14 + 2);
        nwr = 0;
        for (int a = 0; a < MSG_LEN; a++) nwr += int'(c_written[a]);
        chk("restart_all_written", nwr, MSG_LEN);
        chk("restart_queue_empty", expq.size(), 0);

        // Key 0x000249: encrypt, then decrypt the captured ciphertext with a fresh schedule.
        set_ksa(24'h000249);
        set_pt("attack at dawn with the rc four");
        load_mems();
        gen_expected(MSG_LEN);
        run(0, dcyc);
        chk("ksa_err", err, 1'b0);
        chk("ksa_queue_empty", expq.size(), 0);
        for (int a = 0; a < 256; a++) dm[a] = s_img[a];
        di = 8'd0; dj = 8'd0; nwr = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            di = di + 8'd1;
            dj = dj + dm[di];
            dt = dm[di]; dm[di] = dm[dj]; dm[dj] = dt;
            dfa = dm[di] + dm[dj];
            if ((c_mem[k] ^ dm[dfa]) !== p_img[k]) nwr++;
        end
        chk("round_trip_bad_bytes", nwr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
